// File: rtl/rbz_vec_spi_ctrl.sv
// SPI initiator for the raybox-zero vector peripheral.
// Accepts one vector set per valid/ready handshake and shifts it out as a
// single mode-0 frame, MSB first: {px, py, fx, fy, vx, vy}.
module rbz_vec_spi_ctrl #(
    parameter int unsigned POS_W   = 15,
    parameter int unsigned DIR_W   = 12,
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned GAP_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [POS_W-1:0] i_px,
    input  logic [POS_W-1:0] i_py,
    input  logic [DIR_W-1:0] i_fx,
    input  logic [DIR_W-1:0] i_fy,
    input  logic [DIR_W-1:0] i_vx,
    input  logic [DIR_W-1:0] i_vy,
    input  logic             i_start_en,
    output logic             o_sclk,
    output logic             o_mosi,
    output logic             o_ss_n,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned N       = 2 * POS_W + 4 * DIR_W;
    localparam int unsigned BIT_W   = $clog2(N + 1);
    localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] BIT_N    = BIT_W'(N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_EN,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bits_q, bits_d;
    logic [N-1:0]     shift_q, shift_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             ss_n_q, ss_n_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             phase_end;
    logic             gap_end;

    assign phase_end = (cnt_q == DIV_LAST);
    assign gap_end   = (cnt_q == GAP_LAST);

    // Next-state and next-output logic for the frame sequencer.
    // bits_q counts bits still to be presented after the one on mosi, so the
    // HIGH phase of the last bit sees zero and heads to HOLD.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bits_d  = bits_q;
        shift_d = shift_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        ss_n_d  = ss_n_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    shift_d = {i_px, i_py, i_fx, i_fy, i_vx, i_vy};
                    bits_d  = BIT_N;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_WAIT_EN;
                end
            end
            S_WAIT_EN: begin
                if (i_start_en) begin
                    ss_n_d  = 1'b0;
                    mosi_d  = shift_q[N-1];
                    shift_d = {shift_q[N-2:0], 1'b0};
                    bits_d  = bits_q - BIT_ONE;
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP, S_LOW: begin
                if (phase_end) begin
                    sclk_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (phase_end) begin
                    sclk_d = 1'b0;
                    cnt_d  = '0;
                    if (bits_q != '0) begin
                        mosi_d  = shift_q[N-1];
                        shift_d = {shift_q[N-2:0], 1'b0};
                        bits_d  = bits_q - BIT_ONE;
                        state_d = S_LOW;
                    end else begin
                        state_d = S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HOLD: begin
                if (phase_end) begin
                    ss_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset forces the bus idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bits_q  <= '0;
            shift_q <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            ss_n_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            ss_n_q  <= ss_n_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_sclk  = sclk_q;
    assign o_mosi  = mosi_q;
    assign o_ss_n  = ss_n_q;
    assign o_ready = ready_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_rbz_vec_spi_ctrl.sv
// Scoreboard bench for rbz_vec_spi_ctrl: two instances (CLK_DIV=2 and
// CLK_DIV=1); stimulus pushes expected frame words, per-instance monitors
// capture the mode-0 frames and check data and timing.
module tb_rbz_vec_spi_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // instance 0: CLK_DIV=2
    logic        v0, rdy0, en0, sclk0, mosi0, ss0, busy0, done0;
    logic [14:0] px0, py0;
    logic [11:0] fx0, fy0, vx0, vy0;
    // instance 1: CLK_DIV=1
    logic        v1, rdy1, en1, sclk1, mosi1, ss1, busy1, done1;
    logic [14:0] px1, py1;
    logic [11:0] fx1, fy1, vx1, vy1;

    rbz_vec_spi_ctrl #(.POS_W(15), .DIR_W(12), .CLK_DIV(2), .GAP_CYC(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_valid(v0), .o_ready(rdy0),
        .i_px(px0), .i_py(py0), .i_fx(fx0), .i_fy(fy0), .i_vx(vx0), .i_vy(vy0),
        .i_start_en(en0), .o_sclk(sclk0), .o_mosi(mosi0), .o_ss_n(ss0),
        .o_busy(busy0), .o_done(done0)
    );

    rbz_vec_spi_ctrl #(.POS_W(15), .DIR_W(12), .CLK_DIV(1), .GAP_CYC(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_valid(v1), .o_ready(rdy1),
        .i_px(px1), .i_py(py1), .i_fx(fx1), .i_fy(fy1), .i_vx(vx1), .i_vy(vy1),
        .i_start_en(en1), .o_sclk(sclk1), .o_mosi(mosi1), .o_ss_n(ss1),
        .o_busy(busy1), .o_done(done1)
    );

    logic [77:0] q0[$];
    logic [77:0] q1[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- monitor for instance 0 ----------------
    int          low0, rise0, gapw0;
    logic [77:0] cap0;
    logic        pss0, psc0, wgap0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pss0 = 1'b1; psc0 = 1'b0; low0 = 0; rise0 = 0; cap0 = '0; wgap0 = 1'b0; gapw0 = 0;
        end else begin
            if (ss0) begin
                chk("mosi0_idle", mosi0, 1'b0);
                chk("sclk0_idle", sclk0, 1'b0);
            end
            chk("done0_align", done0, (!pss0 && ss0));
            chk("busy0_vs_ready0", busy0, !rdy0);
            if (!ss0) begin
                if (pss0) begin low0 = 0; rise0 = 0; cap0 = '0; end
                low0++;
                if (sclk0 && !psc0) begin
                    if (rise0 == 0) chk("first_rise0", low0 - 1, 2);
                    cap0 = {cap0[76:0], mosi0};
                    rise0++;
                end else if (sclk0) begin
                    chk("mosi0_stable", mosi0, cap0[0]);
                end
            end else if (!pss0) begin
                if (q0.size() == 0) chk("frame0_unexpected", 1, 0);
                else chk("frame0_word", cap0, q0.pop_front());
                chk("frame0_edges", rise0, 78);
                chk("frame0_ss_low", low0, 314);
                wgap0 = 1'b1; gapw0 = 0;
            end
            if (wgap0) begin
                if (rdy0) begin chk("ready0_after_ss", gapw0, 4); wgap0 = 1'b0; end
                else gapw0++;
            end
            pss0 = ss0; psc0 = sclk0;
        end
    end

    // ---------------- monitor for instance 1 ----------------
    int          low1, rise1, hi1;
    logic [77:0] cap1;
    logic        pss1, psc1, seen1;

    always @(negedge clk) begin
        if (!rst_n) begin
            pss1 = 1'b1; psc1 = 1'b0; low1 = 0; rise1 = 0; cap1 = '0; hi1 = 0; seen1 = 1'b0;
        end else begin
            chk("done1_align", done1, (!pss1 && ss1));
            if (!ss1) begin
                if (pss1) begin
                    if (seen1) chk("gap1_min", (hi1 >= 4), 1'b1);
                    low1 = 0; rise1 = 0; cap1 = '0;
                end
                low1++;
                if (sclk1 && !psc1) begin
                    if (rise1 == 0) chk("first_rise1", low1 - 1, 1);
                    cap1 = {cap1[76:0], mosi1};
                    rise1++;
                end
            end else begin
                if (!pss1) begin
                    if (q1.size() == 0) chk("frame1_unexpected", 1, 0);
                    else chk("frame1_word", cap1, q1.pop_front());
                    chk("frame1_edges", rise1, 78);
                    chk("frame1_ss_low", low1, 157);
                    seen1 = 1'b1; hi1 = 0;
                end
                hi1++;
            end
            pss1 = ss1; psc1 = sclk1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send0(input logic [14:0] px, input logic [14:0] py,
                         input logic [11:0] fx, input logic [11:0] fy,
                         input logic [11:0] vx, input logic [11:0] vy, input bit push);
        @(negedge clk);
        for (int c = 0; c < 2000 && !rdy0; c++) @(negedge clk);
        if (!rdy0) chk("send0_ready_timeout", rdy0, 1'b1);
        px0 = px; py0 = py; fx0 = fx; fy0 = fy; vx0 = vx; vy0 = vy; v0 = 1'b1;
        if (push) q0.push_back({px, py, fx, fy, vx, vy});
        @(negedge clk);
        v0 = 1'b0;
    endtask

    task automatic wait_idle0();
        @(negedge clk);
        for (int c = 0; c < 2000 && !rdy0; c++) @(negedge clk);
        chk("idle0_timeout", rdy0, 1'b1);
    endtask

    logic [14:0] tpx[3] = '{15'h1234, 15'h7FFF, 15'h0001};
    logic [14:0] tpy[3] = '{15'h4321, 15'h0000, 15'h5555};
    logic [11:0] tfx[3] = '{12'hABC, 12'h001, 12'h800};
    logic [11:0] tfy[3] = '{12'h123, 12'hFFE, 12'h3C3};
    logic [11:0] tvx[3] = '{12'h0F0, 12'h777, 12'h000};
    logic [11:0] tvy[3] = '{12'hF0F, 12'h888, 12'hFFF};

    initial begin
        rst_n = 1'b0;
        v0 = 1'b0; en0 = 1'b1; px0 = '0; py0 = '0; fx0 = '0; fy0 = '0; vx0 = '0; vy0 = '0;
        v1 = 1'b0; en1 = 1'b1; px1 = '0; py1 = '0; fx1 = '0; fy1 = '0; vx1 = '0; vy1 = '0;
        repeat (3) @(negedge clk);
        // reset values
        chk("rst_sclk0", sclk0, 1'b0); chk("rst_mosi0", mosi0, 1'b0);
        chk("rst_ss0", ss0, 1'b1);     chk("rst_ready0", rdy0, 1'b1);
        chk("rst_busy0", busy0, 1'b0); chk("rst_done0", done0, 1'b0);
        chk("rst_ss1", ss1, 1'b1);     chk("rst_ready1", rdy1, 1'b1);
        #2 rst_n = 1'b1;

        // 1: single frame at defaults
        send0(15'h0ABC, 15'h7001, 12'h400, 12'h000, 12'h000, 12'hF9A, 1'b1);
        wait_idle0();

        // 2: start gated by i_start_en
        en0 = 1'b0;
        send0(15'h2468, 15'h1357, 12'h9AB, 12'hCDE, 12'h010, 12'h020, 1'b1);
        for (int i = 0; i < 50; i++) begin
            chk("gate_ss0", ss0, 1'b1);
            chk("gate_busy0", busy0, 1'b1);
            chk("gate_ready0", rdy0, 1'b0);
            @(negedge clk);
        end
        en0 = 1'b1;
        @(negedge clk);
        chk("start_after_en", ss0, 1'b0);

        // 3: i_valid mid-frame with other data is ignored
        en0 = 1'b0;
        repeat (40) @(negedge clk);
        px0 = 15'h7777; py0 = 15'h0F0F; fx0 = 12'hEEE; fy0 = 12'h111; vx0 = 12'h222; vy0 = 12'h333;
        v0 = 1'b1;
        chk("midframe_ready0", rdy0, 1'b0);
        @(negedge clk);
        chk("midframe_ready0_b", rdy0, 1'b0);
        v0 = 1'b0;
        wait_idle0();
        en0 = 1'b1;

        // 6: all-ones then all-zeros
        send0(15'h7FFF, 15'h7FFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1'b1);
        wait_idle0();
        send0(15'h0000, 15'h0000, 12'h000, 12'h000, 12'h000, 12'h000, 1'b1);
        wait_idle0();

        // 5: reset at the 30th sclk rise, then an intact frame
        begin
            int   r;
            logic p;
            r = 0; p = 1'b0;
            send0(15'h3C3C, 15'h4B4B, 12'h5A5, 12'hA5A, 12'h6C6, 12'hC6C, 1'b0);
            for (int c = 0; c < 3000 && r < 30; c++) begin
                @(negedge clk);
                if (sclk0 && !p) r++;
                p = sclk0;
            end
            chk("rise30_reached", r, 30);
            #2 rst_n = 1'b0;
            #1;
            chk("async_ss0", ss0, 1'b1);
            chk("async_sclk0", sclk0, 1'b0);
            chk("async_done0", done0, 1'b0);
            repeat (3) @(negedge clk);
            chk("rst_hold_done0", done0, 1'b0);
            #2 rst_n = 1'b1;
            @(negedge clk);
            chk("post_rst_ready0", rdy0, 1'b1);
            chk("post_rst_busy0", busy0, 1'b0);
            send0(15'h0102, 15'h0304, 12'h506, 12'h708, 12'h90A, 12'hB0C, 1'b1);
            wait_idle0();
        end

        // 4: CLK_DIV=1, back-to-back with i_valid held high
        @(negedge clk);
        v1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            px1 = tpx[k]; py1 = tpy[k]; fx1 = tfx[k]; fy1 = tfy[k]; vx1 = tvx[k]; vy1 = tvy[k];
            for (int c = 0; c < 2000 && !rdy1; c++) @(negedge clk);
            chk("send1_ready", rdy1, 1'b1);
            q1.push_back({tpx[k], tpy[k], tfx[k], tfy[k], tvx[k], tvy[k]});
            @(negedge clk);
        end
        v1 = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 2000 && !rdy1; c++) @(negedge clk);
        chk("idle1_timeout", rdy1, 1'b1);

        repeat (5) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
